enable_data_gen: RTL
====================

Name: enable_data_gen

Overview:
- Upstream stage that sources the enable/data pair for the enable-data rule checker.
- Accepts a raw byte stream over a valid/ready handshake and discards any byte that breaks the rule (zero or odd).
- Buffers qualified bytes in a small FIFO and presents them as enable/data, so data is non-zero and even whenever enable is high.
- Provides drop/accept statistics and a flush control.

Parameters:
- DATA_W, 8, width of in_data and data.
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- CNT_W, 8, width of the accept_cnt and drop_cnt counters.

Ports:
- clk  input  1  single clock; all logic on posedge.
- rst_n  input  1  synchronous active-low reset, sampled on posedge clk.
- in_valid  input  1  raw byte present.
- in_data  input  DATA_W  raw byte.
- in_ready  output  1  block can take in_data this cycle.
- flush  input  1  discard all buffered entries.
- enable  output  1  data is valid and rule-compliant.
- data  output  DATA_W  head-of-FIFO value; 0 when enable=0.
- out_ready  input  1  downstream consumes the head when enable=1.
- accept_cnt  output  CNT_W  saturating count of bytes written to the FIFO.
- drop_cnt  output  CNT_W  saturating count of bytes discarded at input.

Behaviour:
- Reset, synchronous on rst_n=0 at posedge, applied mid-operation as well:
  - FIFO emptied; state=ST_RUN.
  - enable=0, data=0, in_ready=0 during reset; in_ready=1 in the first cycle after release.
  - accept_cnt=0, drop_cnt=0.
- Handshake:
  - An input transfer occurs when in_valid && in_ready.
  - A byte is qualified when in_data!=0 and in_data[0]==0.
  - A qualified byte is written to the FIFO and accept_cnt increments.
  - A non-qualified byte is consumed, not written, and drop_cnt increments.
- in_ready = (state==ST_RUN) && (!full || pop).
  - The simultaneous pop frees the slot, so a full FIFO still accepts while draining.
- Output:
  - enable = !empty && state==ST_RUN.
  - data = head entry when enable=1, else 0.
  - pop = enable && out_ready.
  - enable/data hold stable while enable=1 && out_ready=0.
- Latency: a qualified byte accepted in cycle N is visible at the output in cycle N+1 at the earliest. There is no combinational in->out bypass.
- Empty FIFO with a write: no pop is possible that cycle; enable rises next cycle.
- Full FIFO with a write and pop in the same cycle: occupancy is unchanged; pointers wrap modulo DEPTH.
- FSM states:
  - ST_RUN: normal operation.
  - ST_FLUSH: entered from ST_RUN when flush=1 at posedge. Lasts exactly one cycle with the FIFO cleared, in_ready=0, enable=0. Returns to ST_RUN unconditionally.
  - A transfer presented in the same cycle flush is sampled is still accepted and counted, then cleared by the flush.
  - flush held high re-enters ST_FLUSH every other cycle.
- Counters saturate at 2**CNT_W-1 and never wrap. Flush does not clear them.

Optional Feature:
- Macro ENABLE_DATA_ODD_ROUND_EN.
- Defined: an odd byte is rounded down (in_data & ~1) and written if the result is non-zero; counts in accept_cnt. 8'd1 rounds to 0 and is dropped.
- Undefined: every odd byte is dropped.
- Zero is dropped in both builds.

Decomposition:
- Package enable_data_pkg:
  - DATA_W_DEF=8, DEPTH_DEF=4.
  - typedef enum logic {ST_RUN, ST_FLUSH} ed_state_t.
  - function is_qualified(byte) returning the rule check, shared with the checker bench.
- One sub-module, ed_sync_fifo:
  - Parameters DATA_W, DEPTH.
  - Ports: clk, rst_n, clr, wr_en, wr_data, rd_en, rd_data, full, empty.
  - Registered storage; synchronous clear.

Test Plan:
- Reset then stream 4, 7, 0, 10 with out_ready=1 -> enable pulses with data 4 then 10; drop_cnt=2, accept_cnt=2; the enable-data checker assertion never fires.
- out_ready=0, push 2, 4, 6, 8, 12 -> in_ready=0 after the 4th write, 12 stalls; raise out_ready -> data order 2, 4, 6, 8, 12; enable stable during the stall.
- Full FIFO, simultaneous write 14 and pop of 2 -> occupancy stays 4, in_ready=1; 14 emerges last; pointer wrap verified.
- Three entries buffered, flush=1 for one cycle -> next cycle enable=0, in_ready=0; following cycle empty, in_ready=1; counters unchanged.
- rst_n=0 mid-stream with 2 entries and accept_cnt=5 -> next cycle enable=0, data=0, counters 0, FIFO empty.
- ENABLE_DATA_ODD_ROUND_EN defined, send 7, 1, 9 -> outputs 6 then 8, drop_cnt=1. Undefined build, same stimulus -> no output, drop_cnt=3.

Source files
------------

// File: rtl/enable_data_pkg.sv
// Shared types and the enable/data rule check for the enable-data generator.
// Also used by the rule-checker bench.
package enable_data_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int DEPTH_DEF  = 4;

    typedef enum logic {
        ST_RUN,
        ST_FLUSH
    } ed_state_t;

    function automatic logic is_qualified(input logic [DATA_W_DEF-1:0] b);
        return (b != '0) && !b[0];
    endfunction

endpackage

// File: rtl/enable_data_gen_fifo.sv
// ed_sync_fifo: registered-storage synchronous FIFO with synchronous clear.
// The read head is presented combinationally from the storage array.
module ed_sync_fifo
    import enable_data_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;
    logic              w_push;
    logic              w_pop;

    assign full    = (r_count == (AW+1)'(DEPTH));
    assign empty   = (r_count == '0);
    assign rd_data = r_mem[r_rd_ptr];

    // A pop in the same cycle frees the slot a full write needs
    assign w_push = wr_en && (!full || rd_en);
    assign w_pop  = rd_en && !empty;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push && w_pop) r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && rst_n && !clr) r_mem[r_wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/enable_data_gen.sv
// Filters a raw byte stream to non-zero even bytes and sources enable/data.
// Build option ENABLE_DATA_ODD_ROUND_EN rounds odd bytes down instead of dropping.
module enable_data_gen
    import enable_data_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              flush,
    output logic              enable,
    output logic [DATA_W-1:0] data,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  accept_cnt,
    output logic [CNT_W-1:0]  drop_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    ed_state_t         r_state;
    ed_state_t         w_state_nxt;
    logic              w_run;
    logic              w_full;
    logic              w_empty;
    logic              w_pop;
    logic              w_xfer;
    logic              w_push;
    logic              w_qual;
    logic              w_clr;
    logic [DATA_W-1:0] w_wr_data;
    logic [DATA_W-1:0] w_rd_data;

`ifdef ENABLE_DATA_ODD_ROUND_EN
    assign w_wr_data = in_data & ~DATA_W'(1);
    assign w_qual    = (w_wr_data != '0);
`else
    assign w_wr_data = in_data;
    assign w_qual    = (in_data != '0) && !in_data[0];
`endif

    // Outputs are held quiet while reset is asserted
    assign w_run    = rst_n && (r_state == ST_RUN);
    assign enable   = w_run && !w_empty;
    assign data     = enable ? w_rd_data : '0;
    assign w_pop    = enable && out_ready;
    assign in_ready = w_run && (!w_full || w_pop);
    assign w_xfer   = in_valid && in_ready;
    assign w_push   = w_xfer && w_qual;
    assign w_clr    = w_run && flush;

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= ST_RUN;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_RUN:   if (flush) w_state_nxt = ST_FLUSH;
            ST_FLUSH: w_state_nxt = ST_RUN;
            default:  w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            accept_cnt <= '0;
            drop_cnt   <= '0;
        end else if (w_xfer) begin
            if (w_qual && accept_cnt != CNT_MAX)
                accept_cnt <= accept_cnt + 1'b1;
            if (!w_qual && drop_cnt != CNT_MAX)
                drop_cnt <= drop_cnt + 1'b1;
        end
    end

    ed_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (w_clr),
        .wr_en   (w_push),
        .wr_data (w_wr_data),
        .rd_en   (w_pop),
        .rd_data (w_rd_data),
        .full    (w_full),
        .empty   (w_empty)
    );

endmodule
